rs_seq: RTL and testbench

- Iterative 8-bit right shifter. It is the right-direction counterpart of the combinational left shifter `ls` in the barrel-shifter lab set.
- A start pulse captures an operand and an amount. The block shifts one bit position per clock, under a small FSM, and then reports the result with a one-cycle done pulse.
- It supports logical, arithmetic and rotate modes.
- It is used as the return path in ls/rs round-trip checks.

---
 rtl/rs_seq.sv | 118 +++++++++++
 tb/tb_rs_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_seq.sv
`default_nettype none
// ============================================================================
// Module      : rs_seq
// Description : Iterative 8-bit right shifter (logical / arithmetic / rotate).
//               A start pulse captures operand, amount and mode; the data is
//               shifted one bit per clock and the result is reported in a
//               registered output together with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] I,
    input  logic [2:0] S,
    input  logic [1:0] M,
    output logic [7:0] O,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] C_MODE_LOGICAL = 2'b00;
    localparam logic [1:0] C_MODE_ARITH   = 2'b01;
    localparam logic [1:0] C_MODE_ROTATE  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_data;
    logic [2:0] r_cnt;
    logic [1:0] r_mode;
    logic [7:0] r_result;
    logic       w_fill;
    logic [7:0] w_shifted;

    // Fill bit entering data[7]; mode 11 falls through to logical.
    always_comb begin
        w_fill = 1'b0;
        case (r_mode)
            C_MODE_LOGICAL: w_fill = 1'b0;
            C_MODE_ARITH:   w_fill = r_data[7];
            C_MODE_ROTATE:  w_fill = r_data[0];
            default:        w_fill = 1'b0;
        endcase
        w_shifted = {w_fill, r_data[7:1]};
    end

    // Next-state decode: S==0 skips straight to DONE, last shift enters DONE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (S == 3'd0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == 3'd1) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath: capture on accept, shift while in SHIFT, load result on finish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data   <= 8'h00;
            r_cnt    <= 3'd0;
            r_mode   <= 2'b00;
            r_result <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_data <= I;
                        r_cnt  <= S;
                        r_mode <= M;
                        if (S == 3'd0) begin
                            r_result <= I;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_data <= w_shifted;
                    r_cnt  <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        r_result <= w_shifted;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign O    = r_result;
    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_rs_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs_seq
// Description : Directed self-checking bench for the iterative right shifter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] I;
    logic [2:0] S;
    logic [1:0] M;
    logic [7:0] O;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    rs_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .I     (I),
        .S     (S),
        .M     (M),
        .O     (O),
        .busy  (busy),
        .done  (done)
    );

    // 10 ns clock; inputs driven and outputs sampled on the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench model of the companion left shifter.
    function automatic logic [7:0] ls_model(input logic [7:0] a, input logic [2:0] sh);
        ls_model = a << sh;
    endfunction

    // Issue one operation and wait (bounded) for done.
    // lat = cycles after the accept edge at which done was seen (0 = timeout).
    task automatic run_op(input logic [7:0] i_v, input logic [2:0] s_v,
                          input logic [1:0] m_v, input bit scramble,
                          output logic [7:0] o_v, output int lat, output int busy_n);
        @(negedge clk);
        start = 1'b1; I = i_v; S = s_v; M = m_v;
        lat = 0; busy_n = 0; o_v = 8'hxx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_n++;
            if (done) begin
                lat = k;
                o_v = O;
                break;
            end
            if (scramble) begin
                I = 8'($urandom);
                S = 3'($urandom);
                M = 2'($urandom);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; I = 8'h5A; S = 3'd0; M = 2'b00;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (O !== 8'h00) begin errors++; $display("FAIL reset_O got=%h exp=00", O); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_modes();
        logic [7:0] o_v;
        int lat, bn;
        logic [7:0] exp_o [3] = '{8'b00000101, 8'b11111101, 8'b10010101};
        for (int m = 0; m < 3; m++) begin
            run_op(8'b10110010, 3'd5, 2'(m), 1'b0, o_v, lat, bn);
            checks++;
            if (o_v !== exp_o[m]) begin errors++; $display("FAIL mode%0d_O got=%h exp=%h", m, o_v, exp_o[m]); end
            checks++;
            if (lat != 6) begin errors++; $display("FAIL mode%0d_latency got=%0d exp=6", m, lat); end
            checks++;
            if (bn != 6) begin errors++; $display("FAIL mode%0d_busy_cycles got=%0d exp=6", m, bn); end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL mode%0d_after_done got done=%b busy=%b exp 0 0", m, done, busy);
            end
        end
    endtask

    task automatic test_boundaries();
        logic [7:0] o_v;
        int lat, bn;
        run_op(8'hA5, 3'd0, 2'b01, 1'b0, o_v, lat, bn);
        checks++;
        if (o_v !== 8'hA5) begin errors++; $display("FAIL s0_O got=%h exp=a5", o_v); end
        checks++;
        if (lat != 1) begin errors++; $display("FAIL s0_latency got=%0d exp=1", lat); end
        run_op(8'h80, 3'd7, 2'b01, 1'b0, o_v, lat, bn);
        checks++;
        if (o_v !== 8'hFF) begin errors++; $display("FAIL s7_arith_O got=%h exp=ff", o_v); end
        checks++;
        if (lat != 8) begin errors++; $display("FAIL s7_latency got=%0d exp=8", lat); end
        run_op(8'h80, 3'd7, 2'b00, 1'b0, o_v, lat, bn);
        checks++;
        if (o_v !== 8'h01) begin errors++; $display("FAIL s7_logical_O got=%h exp=01", o_v); end
        run_op(8'h80, 3'd7, 2'b11, 1'b0, o_v, lat, bn);
        checks++;
        if (o_v !== 8'h01) begin errors++; $display("FAIL s7_mode11_O got=%h exp=01", o_v); end
    endtask

    // Starts during SHIFT and DONE are ignored; a start right after DONE is taken.
    task automatic test_back_to_back();
        int n_done = 0;
        int k_first = 0;
        int k_second = 0;
        logic [7:0] o_first = 8'hxx;
        logic [7:0] o_second = 8'hxx;
        @(negedge clk);
        start = 1'b1; I = 8'hF0; S = 3'd4; M = 2'b00;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (n_done == 1) begin k_first = k; o_first = O; end
                else begin k_second = k; o_second = O; end
            end
            start = 1'b0;
            if (k == 2 || k == 5) begin
                start = 1'b1; I = 8'h0F; S = 3'd1; M = 2'b00;
            end
            if (k == 6) begin
                start = 1'b1; I = 8'h3C; S = 3'd1; M = 2'b01;
            end
        end
        checks++;
        if (k_first != 5 || o_first !== 8'h0F) begin
            errors++; $display("FAIL b2b_first got k=%0d O=%h exp k=5 O=0f", k_first, o_first);
        end
        checks++;
        if (k_second != 8 || o_second !== 8'h1E) begin
            errors++; $display("FAIL b2b_third got k=%0d O=%h exp k=8 O=1e", k_second, o_second);
        end
        checks++;
        if (n_done != 2) begin errors++; $display("FAIL b2b_done_count got=%0d exp=2", n_done); end
    endtask

    task automatic test_abort();
        logic [7:0] o_v;
        int lat, bn;
        int n_done = 0;
        @(negedge clk);
        start = 1'b1; I = 8'hFF; S = 3'd6; M = 2'b00;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) n_done++;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (O !== 8'h00 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_immediate got O=%h busy=%b exp O=00 busy=0", O, busy);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        checks++;
        if (n_done != 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", n_done); end
        run_op(8'h81, 3'd1, 2'b10, 1'b0, o_v, lat, bn);
        checks++;
        if (o_v !== 8'hC0 || lat != 2) begin
            errors++; $display("FAIL abort_recover got O=%h lat=%0d exp O=c0 lat=2", o_v, lat);
        end
    endtask

    task automatic test_round_trip();
        logic [7:0] o_v, exp_v, a;
        logic [2:0] sh;
        int lat, bn;
        for (int s = 0; s < 8; s++) begin
            for (int v = 0; v < 256; v++) begin
                a = 8'(v);
                sh = 3'(s);
                exp_v = a & (8'hFF >> sh);
                run_op(ls_model(a, sh), sh, 2'b00, 1'b0, o_v, lat, bn);
                checks++;
                if (o_v !== exp_v) begin
                    errors++; $display("FAIL round_trip I=%h S=%0d got=%h exp=%h", a, sh, o_v, exp_v);
                end
            end
        end
    endtask

    task automatic test_input_isolation();
        logic [7:0] o_v;
        int lat, bn;
        run_op(8'h96, 3'd3, 2'b01, 1'b1, o_v, lat, bn);
        checks++;
        if (o_v !== 8'hF2 || lat != 4) begin
            errors++; $display("FAIL isolate_arith got O=%h lat=%0d exp O=f2 lat=4", o_v, lat);
        end
        run_op(8'h6B, 3'd6, 2'b10, 1'b1, o_v, lat, bn);
        checks++;
        if (o_v !== 8'hAD || lat != 7) begin
            errors++; $display("FAIL isolate_rotate got O=%h lat=%0d exp O=ad lat=7", o_v, lat);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; I = 8'h00; S = 3'd0; M = 2'b00;
        test_reset();
        test_modes();
        test_boundaries();
        test_back_to_back();
        test_abort();
        test_round_trip();
        test_input_isolation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
